// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with wait-stated memory handshake.
// Optional branch decode (CBZ/CBNZ/B) is enabled by defining MC_CTRL_BRANCH_EN.
module multicycle_control #(
  parameter int unsigned OPCODE_W = 11,
  parameter int unsigned ALUOP_W  = 3,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                zero,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                reg2loc,
  output logic                alu_src,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                beq,
  output logic                bne,
  output logic                jump,
  output logic                illegal,
  output logic                mem_timeout,
  output logic                busy
);

  localparam int unsigned CNT_W = (WAIT_MAX == 0) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_RESET_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_LD,
    CLS_ST,
    CLS_R,
    CLS_CBZ,
    CLS_CBNZ,
    CLS_B,
    CLS_ILL
  } cls_t;

  state_t           state, state_nx;
  cls_t             cls_q, cls_nx, dec_cls;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             in_wait, tmo;

  // Opcode to instruction class; branch patterns only exist when branches are built in
  function automatic cls_t decode_cls(input logic [10:0] op);
    cls_t c;
    c = CLS_ILL;
    casez (op)
      11'b11111000010: c = CLS_LD;
      11'b11111000000: c = CLS_ST;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: c = CLS_R;
`ifdef MC_CTRL_BRANCH_EN
      11'b10110100???: c = CLS_CBZ;
      11'b10110101???: c = CLS_CBNZ;
      11'b000101?????: c = CLS_B;
`endif
      default:         c = CLS_ILL;
    endcase
    return c;
  endfunction

`ifndef MC_CTRL_BRANCH_EN
  logic unused_zero;
  assign unused_zero = zero;
`endif

  assign dec_cls = decode_cls(11'(opcode));
  assign in_wait = (state == S_FETCH) || (state == S_MEM);
  assign tmo     = in_wait && !mem_ready && (WAIT_MAX != 0) && (cnt_q == CNT_W'(WAIT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET_IDLE;
      cls_q <= CLS_NONE;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      cls_q <= cls_nx;
      cnt_q <= cnt_nx;
    end
  end

  // Wait counter restarts whenever a wait state is (re)entered; saturates instead of wrapping
  always_comb begin
    cnt_nx = '0;
    if (in_wait && !mem_ready && !tmo) begin
      cnt_nx = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx    = state;
    cls_nx      = cls_q;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    reg2loc     = 1'b0;
    alu_src     = 1'b0;
    alu_op      = '0;
    beq         = 1'b0;
    bne         = 1'b0;
    jump        = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    busy        = (state != S_RESET_IDLE);

    case (state)
      S_RESET_IDLE: state_nx = S_FETCH;

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end else if (tmo) begin
          mem_timeout = 1'b1;
          state_nx    = S_FETCH;
        end
      end

      // DECODE acts on the live opcode because the class register only loads at its end
      S_DECODE: begin
        cls_nx = dec_cls;
        case (dec_cls)
`ifdef MC_CTRL_BRANCH_EN
          CLS_B: begin
            jump     = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'd2;
            state_nx = S_FETCH;
          end
`endif
          CLS_ILL: begin
            illegal  = 1'b1;
            state_nx = S_FETCH;
          end
          default: state_nx = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (cls_q)
          CLS_LD: begin
            alu_src  = 1'b1;
            state_nx = S_MEM;
          end
          CLS_ST: begin
            alu_src  = 1'b1;
            reg2loc  = 1'b1;
            state_nx = S_MEM;
          end
          CLS_R: begin
            alu_op   = ALUOP_W'(3'b010);
            state_nx = S_WB;
          end
`ifdef MC_CTRL_BRANCH_EN
          CLS_CBZ, CLS_CBNZ: begin
            reg2loc  = 1'b1;
            alu_op   = ALUOP_W'(3'b001);
            pc_src   = 2'd1;
            beq      = (cls_q == CLS_CBZ);
            bne      = (cls_q == CLS_CBNZ);
            pc_write = (cls_q == CLS_CBZ) ? zero : !zero;
            state_nx = S_FETCH;
          end
`endif
          default: state_nx = S_FETCH;
        endcase
      end

      S_MEM: begin
        iord      = 1'b1;
        alu_src   = 1'b1;
        mem_read  = (cls_q == CLS_LD);
        mem_write = (cls_q == CLS_ST);
        reg2loc   = (cls_q == CLS_ST);
        if (mem_ready) begin
          state_nx = (cls_q == CLS_LD) ? S_WB : S_FETCH;
        end else if (tmo) begin
          mem_timeout = 1'b1;
          state_nx    = S_FETCH;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LD);
        state_nx   = S_FETCH;
      end

      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table with reactive memory, reset abort sequence,
// and random instruction streams checked cycle by cycle against a per-instruction trace model.
module tb_multicycle_control;

  localparam int unsigned W = 4;
`ifdef MC_CTRL_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  localparam int C_LD = 0, C_ST = 1, C_R = 2, C_CBZ = 3, C_CBNZ = 4, C_B = 5, C_ILL = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode;
  logic        mem_ready, zero;
  logic        pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write;
  logic        reg2loc, alu_src, beq, bne, jump, illegal, mem_timeout, busy;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;

  multicycle_control #(.OPCODE_W(11), .ALUOP_W(3), .WAIT_MAX(W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
    .beq(beq), .bne(bne), .jump(jump), .illegal(illegal),
    .mem_timeout(mem_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write, reg2loc, alu_src;
    logic [2:0] alu_op;
    logic       beq, bne, jump, illegal, mem_timeout, busy;
  } outs_t;

  typedef struct {
    logic  mr;
    logic  z;
    outs_t o;
  } rec_t;

  typedef struct {
    logic [10:0] op;
    int fw, mw;
    logic z;
    int cyc, rw, pcw, m2r, mwr, mrd, ill, tmo;
  } dir_t;

  outs_t act;
  assign act = {pc_write, pc_src, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write,
                reg2loc, alu_src, alu_op, beq, bne, jump, illegal, mem_timeout, busy};

  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t q[$];
  dir_t tbl[14];

  task automatic chk(input string name, input int a, input int e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic int cls_of(input logic [10:0] op);
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (BR && op ==? 11'b10110100???) return C_CBZ;
    if (BR && op ==? 11'b10110101???) return C_CBNZ;
    if (BR && op ==? 11'b000101?????) return C_B;
    return C_ILL;
  endfunction

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic void push(input outs_t o, input logic mr, input logic z);
    rec_t r;
    r.o = o; r.mr = mr; r.z = z;
    q.push_back(r);
  endfunction

  // Expected cycle trace of one instruction given fetch/mem wait counts
  function automatic void gen(input logic [10:0] op, input int fw, input int mw, input logic z);
    int    c, nto, rem;
    outs_t o;
    c   = cls_of(op);
    nto = fw / (W + 1);
    rem = fw % (W + 1);
    for (int t = 0; t < nto; t++)
      for (int k = 0; k <= W; k++) begin
        o = base(); o.mem_read = 1'b1; o.mem_timeout = (k == W);
        push(o, 1'b0, z);
      end
    for (int k = 0; k < rem; k++) begin
      o = base(); o.mem_read = 1'b1;
      push(o, 1'b0, z);
    end
    o = base(); o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, 1'b1, z);
    o = base();
    if (c == C_B) begin
      o.jump = 1'b1; o.pc_write = 1'b1; o.pc_src = 2'd2;
      push(o, rb(), z);
      return;
    end
    if (c == C_ILL) begin
      o.illegal = 1'b1;
      push(o, rb(), z);
      return;
    end
    push(o, rb(), z);
    o = base();
    case (c)
      C_LD: o.alu_src = 1'b1;
      C_ST: begin o.alu_src = 1'b1; o.reg2loc = 1'b1; end
      C_R:  o.alu_op = 3'b010;
      default: begin
        o.reg2loc = 1'b1; o.alu_op = 3'b001; o.pc_src = 2'd1;
        o.beq = (c == C_CBZ); o.bne = (c == C_CBNZ);
        o.pc_write = (c == C_CBZ) ? z : !z;
      end
    endcase
    push(o, rb(), z);
    if (c == C_CBZ || c == C_CBNZ) return;
    if (c == C_R) begin
      o = base(); o.reg_write = 1'b1;
      push(o, rb(), z);
      return;
    end
    o = base(); o.iord = 1'b1; o.alu_src = 1'b1;
    if (c == C_LD) o.mem_read = 1'b1;
    else begin o.mem_write = 1'b1; o.reg2loc = 1'b1; end
    if (mw > int'(W)) begin
      for (int k = 0; k <= W; k++) begin
        o.mem_timeout = (k == W);
        push(o, 1'b0, z);
      end
      return;
    end
    for (int k = 0; k < mw; k++) push(o, 1'b0, z);
    push(o, 1'b1, z);
    if (c == C_ST) return;
    o = base(); o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
    push(o, rb(), z);
  endfunction

  // Run one instruction with a memory that answers after fw/mw waits; tally observed outputs
  task automatic run_dir(input dir_t e, input int idx);
    int cyc = 0, rw = 0, pcw = 0, m2r = 0, mwr = 0, mrd = 0, ill = 0, tmo = 0, fi = 0, mi = 0;
    bit seen_ir = 0, done = 0;
    opcode = e.op;
    zero   = e.z;
    for (int k = 0; k < 60; k++) begin
      if (mem_read && !iord && seen_ir) begin
        done = 1;
        break;
      end
      if (mem_read && !iord) begin mem_ready = (fi == e.fw); fi++; end
      else if (iord && (mem_read || mem_write)) begin mem_ready = (mi == e.mw); mi++; end
      else mem_ready = 1'b0;
      #2;
      cyc++;
      rw  += int'(reg_write);
      pcw += int'(pc_write);
      m2r += int'(reg_write && mem_to_reg);
      mwr += int'(mem_write);
      mrd += int'(mem_read && iord);
      ill += int'(illegal);
      tmo += int'(mem_timeout);
      if (ir_write) seen_ir = 1;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    chk($sformatf("dir%0d_done", idx), int'(done), 1);
    chk($sformatf("dir%0d_cycles", idx), cyc, e.cyc);
    chk($sformatf("dir%0d_reg_write", idx), rw, e.rw);
    chk($sformatf("dir%0d_pc_write", idx), pcw, e.pcw);
    chk($sformatf("dir%0d_mem_to_reg", idx), m2r, e.m2r);
    chk($sformatf("dir%0d_mem_write", idx), mwr, e.mwr);
    chk($sformatf("dir%0d_data_read", idx), mrd, e.mrd);
    chk($sformatf("dir%0d_illegal", idx), ill, e.ill);
    chk($sformatf("dir%0d_timeout", idx), tmo, e.tmo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rec_t        r;
    logic [10:0] op;
    int          fw, mw;

    tbl[0]  = '{11'b10001011000, 0, 0, 1'b0, 4, 1, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{11'b11111000010, 0, 3, 1'b0, 8, 1, 1, 1, 0, 4, 0, 0};
    tbl[2]  = '{11'b11111000000, 0, 0, 1'b0, 4, 0, 1, 0, 1, 0, 0, 0};
    tbl[3]  = '{11'b10110100101, 0, 0, 1'b1, BR ? 3 : 2, 0, BR ? 2 : 1, 0, 0, 0, BR ? 0 : 1, 0};
    tbl[4]  = '{11'b10110101011, 0, 0, 1'b1, BR ? 3 : 2, 0, 1, 0, 0, 0, BR ? 0 : 1, 0};
    tbl[5]  = '{11'b00010100011, 0, 0, 1'b0, 2, 0, BR ? 2 : 1, 0, 0, 0, BR ? 0 : 1, 0};
    tbl[6]  = '{11'b11111111111, 0, 0, 1'b0, 2, 0, 1, 0, 0, 0, 1, 0};
    tbl[7]  = '{11'b10001011000, 5, 0, 1'b0, 9, 1, 1, 0, 0, 0, 0, 1};
    tbl[8]  = '{11'b11111000010, 0, 6, 1'b0, 8, 0, 1, 0, 0, 5, 0, 1};
    tbl[9]  = '{11'b11001011000, 2, 0, 1'b0, 6, 1, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{11'b11111000000, 1, 2, 1'b0, 7, 0, 1, 0, 3, 0, 0, 0};
    tbl[11] = '{11'b10110101000, 0, 0, 1'b0, BR ? 3 : 2, 0, BR ? 2 : 1, 0, 0, 0, BR ? 0 : 1, 0};
    tbl[12] = '{11'b10101010000, 9, 0, 1'b0, 13, 1, 1, 0, 0, 0, 0, 1};
    tbl[13] = '{11'b10001010000, 0, 4, 1'b0, 4, 1, 1, 0, 0, 0, 0, 0};

    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", int'(act), 0);
    rst = 1'b0;
    #1;
    chk("idle_outputs", int'(act), 0);
    @(posedge clk); #1;
    chk("first_fetch", int'({busy, mem_read, iord}), 3'b110);

    foreach (tbl[i]) run_dir(tbl[i], i);

    // Reset asserted in the middle of an LDUR data access
    opcode = 11'b11111000010; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ldur_in_mem", int'({iord, mem_read, busy}), 3'b111);
    rst = 1'b1;
    #1;
    chk("rst_async_clear", int'(act), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_release_idle", int'(act), 0);
    @(posedge clk); #1;
    chk("rst_then_fetch", int'({busy, mem_read, iord}), 3'b110);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: op = 11'b11111000010;
        1: op = 11'b11111000000;
        2: op = 11'b10001011000;
        3: op = 11'b11001011000;
        4: op = 11'b10001010000;
        5: op = 11'b10101010000;
        6: op = {8'b10110100, 3'($urandom)};
        7: op = {8'b10110101, 3'($urandom)};
        8: op = {6'b000101, 5'($urandom)};
        default: op = 11'($urandom);
      endcase
      fw = ($urandom_range(0, 6) == 0) ? int'($urandom_range(5, 11)) : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 6) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      opcode = op;
      gen(op, fw, mw, rb());
      while (q.size() > 0) begin
        r = q.pop_front();
        mem_ready = r.mr;
        zero      = r.z;
        #3;
        chk($sformatf("rand%0d_cycle", i), int'(act), int'(r.o));
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
